ps2_key_queue: RTL and testbench

PS2_KEY_QUEUE -- requirements
Module: ps2_key_queue

---
 rtl/ps2_key_queue.sv | 159 +++++++++++++++
 tb/tb_ps2_key_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_queue.sv
// PS/2 key event queue: detects HPS key toggles, buffers events in a FIFO and
// replays them as rate-limited key_ready strobes.
module ps2_key_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [10:0]              ps2_key,
  input  logic                     flush,
  output logic                     key_ready,
  output logic                     key_stroke,
  output logic [9:0]               key_code,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [LW-1:0] level_q,   level_d;
  logic          overflow_q, overflow_d;
  logic          ready_q,   ready_d;
  logic          stroke_q,  stroke_d;
  logic [9:0]    code_q,    code_d;
  logic          prev_tog_q, prev_tog_d;
  logic          armed_q,   armed_d;

  logic [9:0]    mem_q [DEPTH];

  logic          event_c;
  logic          full_c;
  logic          gap_done_c;
  logic          pop_c;
  logic          push_c;
  logic          drop_c;
  logic [9:0]    entry_c;
  logic [9:0]    head_c;

  // Entry layout: {break, extended, scancode}
  assign entry_c    = {~ps2_key[9], ps2_key[8], ps2_key[7:0]};
  assign head_c     = mem_q[rd_ptr_q];
  assign event_c    = armed_q && (ps2_key[10] != prev_tog_q);
  assign full_c     = (level_q == LW'(DEPTH));
  assign gap_done_c = (state_q == ST_GAP) && (gap_cnt_q == '0);

  // An expiring GAP falls through IDLE on the same edge so strobes stay exactly GAP_CYCLES apart
  assign pop_c  = !flush && (level_q != '0) && ((state_q == ST_IDLE) || gap_done_c);
  assign push_c = !flush && event_c && (!full_c || pop_c);
  assign drop_c = !flush && event_c && full_c && !pop_c;

  // Next-state logic for queue, output FSM and edge detector
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + LW'(push_c) - LW'(pop_c);
    overflow_d = overflow_q | drop_c;
    ready_d    = 1'b0;
    stroke_d   = stroke_q;
    code_d     = code_q;
    prev_tog_d = ps2_key[10];
    armed_d    = 1'b1;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_EMIT: begin
        gap_cnt_d = GW'(GAP_CYCLES - 2);
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      ready_d  = 1'b1;
      stroke_d = head_c[9];
      code_d   = {1'b0, head_c[8:0]};
      state_d  = ST_EMIT;
    end

    if (flush) begin
      state_d    = ST_IDLE;
      gap_cnt_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      ready_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
      stroke_q   <= 1'b0;
      code_q     <= '0;
      prev_tog_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      stroke_q   <= stroke_d;
      code_q     <= code_d;
      prev_tog_q <= prev_tog_d;
      armed_q    <= armed_d;
    end
  end

  // Storage needs no reset: level and pointers define which entries are live
  always_ff @(posedge clk_sys) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= entry_c;
    end
  end

  assign key_ready  = ready_q;
  assign key_stroke = stroke_q;
  assign key_code   = code_q;
  assign overflow   = overflow_q;
  assign level      = level_q;

endmodule

// File: tb/tb_ps2_key_queue.sv
// Directed bench for ps2_key_queue with a scoreboard of expected strobes.
module tb_ps2_key_queue;

  localparam int DEPTH = 8;
  localparam int GAP   = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        flush   = 1'b0;
  logic        key_ready;
  logic        key_stroke;
  logic [9:0]  key_code;
  logic        overflow;
  logic [3:0]  level;

  ps2_key_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .flush      (flush),
    .key_ready  (key_ready),
    .key_stroke (key_stroke),
    .key_code   (key_code),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk_sys = ~clk_sys;

  logic [10:0] sb[$];
  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int last_strobe = -1;
  int strobes     = 0;
  int peak        = 0;
  bit chk_gap     = 1'b0;
  logic tog       = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [10:0] exp;
    if (key_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_strobe", {21'd0, key_stroke, key_code}, 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        chk("strobe", {21'd0, key_stroke, key_code}, {21'd0, exp});
      end
      if (chk_gap && last_strobe >= 0)
        chk("spacing", 32'(cycle - last_strobe), 32'(GAP));
      last_strobe = cycle;
      strobes++;
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cycle++;
    if (int'(level) > peak) peak = int'(level);
    monitor();
  endtask

  task automatic ev(input logic pressed, input logic ext, input logic [7:0] sc, input bit exp_ok);
    tog = ~tog;
    ps2_key = {tog, pressed, ext, sc};
    if (exp_ok) sb.push_back({~pressed, 1'b0, ext, sc});
    tick();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    for (int i = 0; i < GAP + 4; i++) tick();
  endtask

  initial begin
    int n;
    // Reset state
    ps2_key = '0;
    #1;
    chk("rst_ready", {31'd0, key_ready}, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_code", {21'd0, key_stroke, key_code}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();

    // Single make 0x1C with latency check
    ev(1'b1, 1'b0, 8'h1C, 1'b1);
    n = cycle;
    chk("single_level", {28'd0, level}, 32'd1);
    chk("single_no_early", {31'd0, key_ready}, 32'd0);
    tick();
    chk("single_latency", 32'(last_strobe), 32'(n + 1));
    drain(50);
    chk("single_hold", {21'd0, key_stroke, key_code}, {21'd0, 1'b0, 10'h01C});

    // Extended release 0x75
    ev(1'b0, 1'b1, 8'h75, 1'b1);
    drain(50);
    chk("ext_hold", {21'd0, key_stroke, key_code}, {21'd0, 1'b1, 10'h175});

    // Burst of 5 back-to-back events
    chk_gap = 1'b1; last_strobe = -1; strobes = 0; peak = 0;
    for (int i = 0; i < 5; i++) ev(i[0], i[1], 8'h20 + 8'(i), 1'b1);
    drain(200);
    chk("burst_peak", 32'(peak), 32'd4);
    chk("burst_count", 32'(strobes), 32'd5);
    chk("burst_ovf", {31'd0, overflow}, 32'd0);

    // Overflow: 10 events, 10th dropped
    last_strobe = -1; strobes = 0;
    for (int i = 0; i < 10; i++) ev(1'b1, 1'b0, 8'h40 + 8'(i), i < 9);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_level", {28'd0, level}, 32'd8);
    drain(400);
    chk("ovf_count", 32'(strobes), 32'd9);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ovf_flushed", {31'd0, overflow}, 32'd0);

    // Flush at level 3 in GAP with a coincident event
    chk_gap = 1'b0;
    ev(1'b1, 1'b0, 8'h11, 1'b1);
    ev(1'b1, 1'b0, 8'h12, 1'b0);
    ev(1'b1, 1'b0, 8'h13, 1'b0);
    ev(1'b1, 1'b0, 8'h14, 1'b0);
    chk("pre_flush_level", {28'd0, level}, 32'd3);
    flush = 1'b1;
    ev(1'b1, 1'b0, 8'h15, 1'b0);
    flush = 1'b0;
    chk("flush_level", {28'd0, level}, 32'd0);
    chk("flush_ready", {31'd0, key_ready}, 32'd0);
    for (int i = 0; i < 100; i++) tick();
    chk("flush_quiet_level", {28'd0, level}, 32'd0);

    // Reset mid-GAP with toggle held high across release
    ev(1'b1, 1'b0, 8'h31, 1'b1);
    ev(1'b1, 1'b0, 8'h32, 1'b0);
    ev(1'b1, 1'b0, 8'h33, 1'b0);
    tick(); tick();
    tog = 1'b1;
    ps2_key = {1'b1, 10'h0_29};
    reset_n = 1'b0;
    #1;
    chk("rst_mid_level", {28'd0, level}, 32'd0);
    chk("rst_mid_code", {21'd0, key_stroke, key_code}, 32'd0);
    tick(); tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("rst_hold_level", {28'd0, level}, 32'd0);
    strobes = 0;
    ev(1'b1, 1'b0, 8'h29, 1'b1);
    drain(50);
    chk("rst_toggle_count", 32'(strobes), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
